// File: rtl/temp_sensor_spi_reader.sv
// SPI master: reads one 16-bit MAX6675-style frame and decodes it into temperature and fault flags.
// data_valid arrives 2*CS_GUARD + 32*SCK_HALF + 1 cycles after start; start is ignored while busy.
module temp_sensor_spi_reader #(
   parameter int SCK_HALF = 50,
   parameter int CS_GUARD = 10
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic        start,
   input  logic        miso,
   output logic        cs_n,
   output logic        sck,
   output logic        busy,
   output logic        data_valid,
   output logic [11:0] temp_raw,
   output logic [9:0]  temp_int,
   output logic        open_fault,
   output logic        frame_error
);
   localparam int HW = $clog2(SCK_HALF);
   localparam int GW = (CS_GUARD > 1) ? $clog2(CS_GUARD) : 1;
   localparam logic [HW-1:0] HALF_LAST  = HW'(SCK_HALF - 1);
   localparam logic [GW-1:0] GUARD_LAST = GW'(CS_GUARD - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   half_q, half_d;
   logic            phase_q, phase_d;
   logic [4:0]      bit_q, bit_d;
   logic [GW-1:0]   guard_q, guard_d;
   logic [15:0]     shift_q, shift_d;
   logic            miso_meta, miso_sync;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         half_q      <= '0;
         phase_q     <= 1'b0;
         bit_q       <= '0;
         guard_q     <= '0;
         shift_q     <= '0;
         miso_meta   <= 1'b0;
         miso_sync   <= 1'b0;
         data_valid  <= 1'b0;
         temp_raw    <= '0;
         temp_int    <= '0;
         open_fault  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state_q    <= state_d;
         half_q     <= half_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         guard_q    <= guard_d;
         shift_q    <= shift_d;
         miso_meta  <= miso;
         miso_sync  <= miso_meta;
         data_valid <= (state_q == DONE);
         if (state_q == DONE) begin
            temp_raw    <= shift_q[14:3];
            temp_int    <= shift_q[14:5];
            open_fault  <= shift_q[2];
            frame_error <= shift_q[15];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      guard_d = guard_q;
      shift_d = shift_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETUP;
               guard_d = '0;
            end
         end
         SETUP: begin
            if (guard_q == GUARD_LAST) begin
               state_d = SHIFT;
               guard_d = '0;
               half_d  = '0;
               phase_d = 1'b0;
               bit_d   = '0;
            end else begin
               guard_d = guard_q + 1'b1;
            end
         end
         SHIFT: begin
            if (half_q != HALF_LAST) begin
               half_d = half_q + 1'b1;
            end else begin
               half_d  = '0;
               phase_d = ~phase_q;
               // End of the high phase: capture the bit, then sck falls.
               if (phase_q) begin
                  shift_d = {shift_q[14:0], miso_sync};
                  bit_d   = bit_q + 5'd1;
                  if (bit_d == 5'd16) begin
                     state_d = HOLD;
                     guard_d = '0;
                  end
               end
            end
         end
         HOLD: begin
            if (guard_q == GUARD_LAST) begin
               state_d = DONE;
               guard_d = '0;
            end else begin
               guard_d = guard_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Decoded from the state register so reset forces them immediately.
   assign cs_n = (state_q == IDLE);
   assign busy = (state_q != IDLE);
   assign sck  = (state_q == SHIFT) && phase_q;

endmodule

// File: tb/tb_temp_sensor_spi_reader.sv
// Self-checking bench for temp_sensor_spi_reader: sensor model on cs_n/sck, table-driven and random frames.
module tb_temp_sensor_spi_reader;
   localparam int SH  = 50;
   localparam int CG  = 10;
   localparam int LAT = 2*CG + 32*SH + 1;

   logic        clk_in = 1'b0;
   logic        rst_n  = 1'b0;
   logic        start  = 1'b0;
   logic        miso;
   logic        cs_n, sck, busy, data_valid, open_fault, frame_error;
   logic [11:0] temp_raw;
   logic [9:0]  temp_int;

   int compared   = 0;
   int mismatched = 0;

   temp_sensor_spi_reader #(.SCK_HALF(SH), .CS_GUARD(CG)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .start(start), .miso(miso),
      .cs_n(cs_n), .sck(sck), .busy(busy), .data_valid(data_valid),
      .temp_raw(temp_raw), .temp_int(temp_int),
      .open_fault(open_fault), .frame_error(frame_error)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // Sensor model: MSB presented on cs_n fall, next bit on each sck fall.
   logic [15:0] frame_v = 16'h0;
   int bit_idx = -1;
   always @(negedge cs_n) bit_idx = 15;
   always @(negedge sck) if (!cs_n) bit_idx = bit_idx - 1;
   assign miso = (bit_idx >= 0) ? frame_v[bit_idx[3:0]] : 1'b0;

   // Edge monitor, sampled on the falling clock edge.
   logic sck_p = 1'b0, cs_p = 1'b1, first_pending = 1'b0;
   int rises = 0, dvs = 0, period_bad = 0, last_rise = 0, cs_fall_cyc = 0, setup_cyc = 0;
   always @(negedge clk_in) begin
      if (!cs_n && cs_p) begin
         cs_fall_cyc   = cyc;
         first_pending = 1'b1;
      end
      if (sck && !sck_p) begin
         if (first_pending) begin
            setup_cyc     = cyc - cs_fall_cyc;
            first_pending = 1'b0;
         end else if (cyc - last_rise != 2*SH) begin
            period_bad++;
         end
         rises++;
         last_rise = cyc;
      end
      if (data_valid) dvs++;
      sck_p = sck;
      cs_p  = cs_n;
   end

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input int raw, input int ti, input int op, input int fe);
      check({tag, ".temp_raw"},    int'(temp_raw),    raw);
      check({tag, ".temp_int"},    int'(temp_int),    ti);
      check({tag, ".open_fault"},  int'(open_fault),  op);
      check({tag, ".frame_error"}, int'(frame_error), fe);
   endtask

   // Reference decode from the frame's bit-field definitions, using plain arithmetic.
   task automatic check_model(input string tag, input logic [15:0] f);
      int v;
      v = int'(f);
      check_out(tag, (v / 8) % 4096, (v / 32) % 1024, (v / 4) % 2, (v >= 32768) ? 1 : 0);
   endtask

   task automatic run_frame(input string tag, input logic [15:0] f, input bit repulse);
      int r0, p0, d0, s, lat;
      bit got, busy_ok;
      frame_v = f;
      r0 = rises; p0 = period_bad; d0 = dvs;
      got = 1'b0; busy_ok = 1'b1; lat = 0;
      @(negedge clk_in); start = 1'b1;
      @(negedge clk_in); start = 1'b0; s = cyc;
      for (int n = 1; n <= LAT + 50 && !got; n++) begin
         start = repulse && (n == 5 || n == 800);
         @(negedge clk_in);
         if (data_valid) begin
            got = 1'b1;
            lat = cyc - s;
         end else if (!busy) begin
            busy_ok = 1'b0;
         end
      end
      start = 1'b0;
      check({tag, ".dv_seen"}, int'(got), 1);
      if (got) check({tag, ".latency"}, lat, LAT);
      check({tag, ".busy_held"}, int'(busy_ok), 1);
      check({tag, ".busy_at_dv"}, int'(busy), 0);
      check({tag, ".cs_n_at_dv"}, int'(cs_n), 1);
      repeat (4) @(negedge clk_in);
      check({tag, ".dv_pulses"}, dvs - d0, 1);
      check({tag, ".sck_rises"}, rises - r0, 16);
      check({tag, ".sck_period"}, period_bad - p0, 0);
   endtask

   typedef struct {
      logic [15:0] frame;
      int raw, ti, op, fe;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{16'h0C88, 401,  100,  0, 0};
      vecs[1] = '{16'h0004, 0,    0,    1, 0};
      vecs[2] = '{16'h8000, 0,    0,    0, 1};
      vecs[3] = '{16'h0C88, 401,  100,  0, 0};
      vecs[4] = '{16'h7FF8, 4095, 1023, 0, 0};
      vecs[5] = '{16'hFFFF, 4095, 1023, 1, 1};
      vecs[6] = '{16'h0003, 0,    0,    0, 0};

      repeat (3) @(negedge clk_in);
      check("rst.cs_n", int'(cs_n), 1);
      check("rst.sck", int'(sck), 0);
      check("rst.busy", int'(busy), 0);
      check("rst.data_valid", int'(data_valid), 0);
      check_out("rst", 0, 0, 0, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_in);

      for (int i = 0; i < 7; i++) begin
         run_frame($sformatf("vec%0d", i), vecs[i].frame, 1'b0);
         check_out($sformatf("vec%0d", i), vecs[i].raw, vecs[i].ti, vecs[i].op, vecs[i].fe);
         check($sformatf("vec%0d.setup", i), setup_cyc, CG + SH);
      end

      // Starts during a frame are ignored.
      run_frame("repulse", 16'h0C88, 1'b1);
      check_out("repulse", 401, 100, 0, 0);

      // Asynchronous reset during bit 7.
      begin
         int r0;
         bit reached;
         r0 = rises; reached = 1'b0;
         frame_v = 16'($urandom);
         @(negedge clk_in); start = 1'b1;
         @(negedge clk_in); start = 1'b0;
         for (int n = 0; n < LAT && !reached; n++) begin
            @(negedge clk_in);
            reached = (rises - r0 >= 8);
         end
         check("midrst.reached_bit7", int'(reached), 1);
         repeat (20) @(negedge clk_in);
         rst_n = 1'b0;
         #1;
         check("midrst.cs_n", int'(cs_n), 1);
         check("midrst.sck", int'(sck), 0);
         check("midrst.busy", int'(busy), 0);
         check_out("midrst", 0, 0, 0, 0);
         @(negedge clk_in); rst_n = 1'b1;
         repeat (5) @(negedge clk_in);
         run_frame("postrst", 16'h0C88, 1'b0);
         check_out("postrst", 401, 100, 0, 0);
      end

      // start held high across two frames.
      begin
         int d1, d2, k, d0;
         bit cs_gap;
         d1 = 0; d2 = 0; k = 0; cs_gap = 1'b0; d0 = dvs;
         frame_v = 16'h0C88;
         @(negedge clk_in); start = 1'b1;
         for (int n = 0; n < 2*LAT + 100 && k < 2; n++) begin
            @(negedge clk_in);
            if (data_valid) begin
               if (k == 0) begin
                  d1 = cyc;
                  cs_gap = cs_n;
               end else begin
                  d2 = cyc;
                  start = 1'b0;
               end
               k++;
            end
         end
         start = 1'b0;
         check("held.dv_count", k, 2);
         check("held.spacing", d2 - d1, LAT + 1);
         check("held.cs_gap", int'(cs_gap), 1);
         check("held.setup", setup_cyc, CG + SH);
         repeat (10) @(negedge clk_in);
         check("held.idle_after", int'(busy), 0);
         check("held.total_dv", dvs - d0, 2);
         check_out("held", 401, 100, 0, 0);
      end

      for (int i = 0; i < 6; i++) begin
         logic [15:0] f;
         f = 16'($urandom);
         run_frame($sformatf("rnd%0d", i), f, 1'b0);
         check_model($sformatf("rnd%0d", i), f);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
